jenc_mcu_sequencer: RTL and testbench

Block sequencer between the zigzag reorder stage and the entropy coder. It accepts the zigzag coefficient-pair stream and tracks beat, block-in-MCU and MCU counters for a frame. It tags every pair with component, start-of-block, end-of-block and end-of-frame, and gates the upstream stream so that only one frame's worth of blocks passes per `start`. It also owns frame start/done/abort handshaking toward the camera control logic.

---
 rtl/jenc_mcu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_jenc_mcu_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jenc_mcu_sequencer.sv
// Sequences zigzag coefficient pairs into blocks/MCUs for the entropy coder,
// tagging component and block/frame boundaries and gating one frame per start.
module jenc_mcu_sequencer #(
    parameter int QW = 15,
    parameter int MW = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    input  logic                mode_420,
    input  logic [MW-1:0]       mcu_total,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic [1:0][QW-1:0]  d,
    input  logic [4:0]          d_cnt,
    input  logic                d_valid,
    output logic                d_hold,
    output logic [1:0][QW-1:0]  q,
    output logic [1:0]          q_comp,
    output logic                q_sob,
    output logic                q_eob,
    output logic                q_eof,
    output logic                q_valid,
    input  logic                q_hold
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [MW-1:0]       last_mcu_q, last_mcu_d;
    logic [4:0]          beat_q, beat_d;
    logic [2:0]          blk_q, blk_d;
    logic [MW-1:0]       mcu_q, mcu_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0][QW-1:0]  q_q, q_d;
    logic [1:0]          comp_q, comp_d;
    logic                sob_q, sob_d, eob_q, eob_d, eof_q, eof_d;
    logic                q_valid_q, q_valid_d;

    logic                xfer;
    logic [2:0]          last_blk;
    logic [1:0]          comp_cur;
    logic                eob_cur, eof_cur;

    // No skid buffer: upstream stalls directly on the downstream stall.
    assign d_hold = (state_q != RUN) | q_hold;
    assign xfer   = d_valid & ~d_hold;

    always_comb begin
        last_blk = mode_q ? 3'd5 : 3'd2;
        comp_cur = blk_q[1:0];
        if (mode_q) begin
            if (blk_q < 3'd4)       comp_cur = 2'd0;
            else if (blk_q == 3'd4) comp_cur = 2'd1;
            else                    comp_cur = 2'd2;
        end
        eob_cur = (beat_q == 5'd31);
        eof_cur = eob_cur & (blk_q == last_blk) & (mcu_q == last_mcu_q);
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        last_mcu_d = last_mcu_q;
        beat_d     = beat_q;
        blk_d      = blk_q;
        mcu_d      = mcu_q;
        done_d     = 1'b0;
        err_d      = err_q;
        q_d        = q_q;
        comp_d     = comp_q;
        sob_d      = sob_q;
        eob_d      = eob_q;
        eof_d      = eof_q;
        q_valid_d  = q_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode_420;
                    last_mcu_d = mcu_total - MW'(1);
                    err_d      = 1'b0;
                    beat_d     = '0;
                    blk_d      = '0;
                    mcu_d      = '0;
                    if (mcu_total == '0) done_d  = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    beat_d = beat_q + 5'd1;
                    if (d_cnt != beat_q) err_d = 1'b1;
                    if (eob_cur) begin
                        if (blk_q == last_blk) begin
                            blk_d = '0;
                            mcu_d = mcu_q + MW'(1);
                        end else begin
                            blk_d = blk_q + 3'd1;
                        end
                    end
                    if (eof_cur) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!q_valid_q || !q_hold) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            q_d       = d;
            comp_d    = comp_cur;
            sob_d     = (beat_q == 5'd0);
            eob_d     = eob_cur;
            eof_d     = eof_cur;
            q_valid_d = 1'b1;
        end else if (!q_hold) begin
            q_valid_d = 1'b0;
        end

        // Abort drops any start in the same cycle and keeps the sticky error.
        if (abort) begin
            state_d   = IDLE;
            q_valid_d = 1'b0;
            beat_d    = '0;
            blk_d     = '0;
            mcu_d     = '0;
            done_d    = 1'b0;
            err_d     = err_q;
        end
    end

    assign busy_d = (state_d == RUN);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            last_mcu_q <= '0;
            beat_q     <= '0;
            blk_q      <= '0;
            mcu_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            q_q        <= '0;
            comp_q     <= '0;
            sob_q      <= 1'b0;
            eob_q      <= 1'b0;
            eof_q      <= 1'b0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            last_mcu_q <= last_mcu_d;
            beat_q     <= beat_d;
            blk_q      <= blk_d;
            mcu_q      <= mcu_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            q_q        <= q_d;
            comp_q     <= comp_d;
            sob_q      <= sob_d;
            eob_q      <= eob_d;
            eof_q      <= eof_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign q       = q_q;
    assign q_comp  = comp_q;
    assign q_sob   = sob_q;
    assign q_eob   = eob_q;
    assign q_eof   = eof_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_jenc_mcu_sequencer.sv
// Scoreboard bench: the driver pushes the expected tagged pair for every accepted
// beat; a negedge monitor pops and compares whenever the output is consumed.
module tb_jenc_mcu_sequencer;
    localparam int QW = 15;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic resetn, start, abort, mode_420;
    logic [MW-1:0] mcu_total;
    logic busy, done, err;
    logic [1:0][QW-1:0] d, q;
    logic [4:0] d_cnt;
    logic d_valid, d_hold;
    logic [1:0] q_comp;
    logic q_sob, q_eob, q_eof, q_valid, q_hold;

    jenc_mcu_sequencer #(.QW(QW), .MW(MW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .mode_420(mode_420), .mcu_total(mcu_total),
        .busy(busy), .done(done), .err(err),
        .d(d), .d_cnt(d_cnt), .d_valid(d_valid), .d_hold(d_hold),
        .q(q), .q_comp(q_comp), .q_sob(q_sob), .q_eob(q_eob), .q_eof(q_eof),
        .q_valid(q_valid), .q_hold(q_hold)
    );

    always #5 clk = ~clk;

    typedef logic [2*QW+4:0] exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1, eof_cnt = 0, eof_cyc = -1;
    bit hold_rand = 0, chk_stable = 0;
    bit cur_mode;
    int cur_total;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [1:0][QW-1:0] data_for(input int k);
        logic [1:0][QW-1:0] dv;
        dv[0] = QW'(k * 3 + 1);
        dv[1] = QW'(32767 - k * 5);
        return dv;
    endfunction

    function automatic exp_t model(input int k);
        int b, blk, m, bpm;
        logic [1:0] c;
        bpm = cur_mode ? 6 : 3;
        b   = k % 32;
        blk = (k / 32) % bpm;
        m   = k / (32 * bpm);
        if (cur_mode) c = (blk < 4) ? 2'd0 : (blk == 4) ? 2'd1 : 2'd2;
        else          c = 2'(blk);
        return {data_for(k), c, (b == 0), (b == 31),
                ((b == 31) && (blk == bpm - 1) && (m == cur_total - 1))};
    endfunction

    exp_t prev;
    bit prev_held = 0;
    always @(negedge clk) begin
        exp_t act, e;
        act = {q, q_comp, q_sob, q_eob, q_eof};
        if (chk_stable && prev_held) chk("hold_stable", act, prev);
        prev = act;
        prev_held = q_valid && q_hold;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (q_valid && !q_hold) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", act);
            end else begin
                e = sb.pop_front();
                chk("beat", act, e);
                if (q_eof) begin
                    eof_cnt++;
                    eof_cyc = cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_rand) q_hold = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit m, input int t);
        mode_420  = m;
        mcu_total = MW'(t);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mode_420  = ~m;
        mcu_total = '0;
        cur_mode  = m;
        cur_total = t;
    endtask

    task automatic send_beat(input int k, input int cnt);
        d       = data_for(k);
        d_cnt   = 5'(cnt);
        d_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!d_hold) begin
                sb.push_back(model(k));
                tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL beat_accept: beat %0d not accepted within 200 cycles", k);
    endtask

    task automatic run_beats(input int first, input int last, input int bad_k, input int bad_cnt);
        for (int k = first; k <= last; k++)
            send_beat(k, (k == bad_k) ? bad_cnt : (k % 32));
        d_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int e0);
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt > d0) break;
            tick();
        end
        chk({name, "_done_cnt"}, done_cnt, d0 + 1);
        chk({name, "_done_after_eof"}, done_cyc, eof_cyc + 1);
        chk({name, "_eof_cnt"}, eof_cnt, e0 + 1);
        repeat (3) tick();
        chk({name, "_done_single"}, done_cnt, d0 + 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_busy_after"}, busy, 1'b0);
        chk({name, "_dhold_after"}, d_hold, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; mode_420 = 1'b0;
        mcu_total = '0; d = '0; d_cnt = '0; d_valid = 1'b0; q_hold = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_dhold", d_hold, 1'b1);
        chk("rst_qvalid", q_valid, 1'b0);
        chk("rst_q", q, '0);
        chk("rst_tags", {q_comp, q_sob, q_eob, q_eof}, '0);
        resetn = 1'b1;
        tick();
        chk("idle_dhold", d_hold, 1'b1);

        // 4:4:4, one MCU, no stalls
        d0 = done_cnt; e0 = eof_cnt;
        start_frame(1'b0, 1);
        chk("f1_busy", busy, 1'b1);
        run_beats(0, 95, -1, 0);
        wait_done("f1", d0, e0);
        chk("f1_err", err, 1'b0);

        // 4:2:0, two MCUs, random downstream stalls
        d0 = done_cnt; e0 = eof_cnt;
        chk_stable = 1;
        hold_rand  = 1;
        start_frame(1'b1, 2);
        run_beats(0, 383, -1, 0);
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt > d0) break;
            tick();
        end
        hold_rand = 0;
        q_hold    = 1'b0;
        wait_done("f420", d0, e0);
        chk_stable = 0;

        // beat-count mismatch on beat 5
        d0 = done_cnt; e0 = eof_cnt;
        start_frame(1'b0, 1);
        run_beats(0, 5, 5, 7);
        chk("err_set", err, 1'b1);
        run_beats(6, 95, -1, 0);
        wait_done("ferr", d0, e0);
        chk("err_sticky", err, 1'b1);
        start_frame(1'b0, 0);
        chk("zero_done", done, 1'b1);
        chk("zero_err_clr", err, 1'b0);
        chk("zero_busy", busy, 1'b0);
        chk("zero_dhold", d_hold, 1'b1);
        tick();
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_dhold2", d_hold, 1'b1);

        // abort mid-block at beat 40
        d0 = done_cnt;
        start_frame(1'b0, 1);
        run_beats(0, 39, -1, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_qvalid", q_valid, 1'b0);
        chk("abort_dhold", d_hold, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_sb_empty", sb.size(), 0);
        d0 = done_cnt; e0 = eof_cnt;
        start_frame(1'b0, 1);
        run_beats(0, 95, -1, 0);
        wait_done("fpost", d0, e0);

        // start while running is ignored
        d0 = done_cnt; e0 = eof_cnt;
        start_frame(1'b0, 1);
        run_beats(0, 9, -1, 0);
        start = 1'b1; mode_420 = 1'b1; mcu_total = MW'(5);
        send_beat(10, 10);
        start = 1'b0; mcu_total = '0;
        run_beats(11, 95, -1, 0);
        wait_done("frun", d0, e0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; mcu_total = MW'(3);
        tick();
        start = 1'b0; abort = 1'b0; mcu_total = '0;
        chk("sa_busy", busy, 1'b0);
        chk("sa_done", done, 1'b0);
        tick();
        chk("sa_dhold", d_hold, 1'b1);

        // synchronous reset mid-frame
        start_frame(1'b0, 1);
        run_beats(0, 40, 3, 0);
        resetn = 1'b0;
        tick();
        chk("mrst_qvalid", q_valid, 1'b0);
        chk("mrst_q", q, '0);
        chk("mrst_tags", {q_comp, q_sob, q_eob, q_eof}, '0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", err, 1'b0);
        chk("mrst_dhold", d_hold, 1'b1);
        resetn  = 1'b1;
        d_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("mrst_dhold_idle", d_hold, 1'b1);
            chk("mrst_qvalid_idle", q_valid, 1'b0);
        end
        d_valid = 1'b0;
        tick();
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
